decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: width of immediate_val, jump_addr and mem_im_addr.
REQ-002 Parameter REG_W, default 4: register-select width; 2**REG_W architectural registers.
REQ-003 Parameter BR_SHIFT, default 0: left shift applied to the sign-extended branch offset (0 or 2).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 instr_valid  in  1  instr carries a valid instruction.
REQ-007 instr  in  32  instruction word.
REQ-008 instr_ready  out  1  instruction accepted on cycles where instr_valid && instr_ready.
REQ-009 flags  in  4  NZCV flags {N,Z,C,V}, sampled on the accept cycle.
REQ-010 stall  in  1  downstream hold; registered outputs freeze.
REQ-011 flush  in  1  discard the current micro-op and any pending sequence.
REQ-012 out_valid  out  1  registered micro-op outputs are valid.
REQ-013 alu_op  out  4  ALU opcode.
REQ-014 reg_write_enable, immediate, jump_en, mem_load, mem_store, mem_base_offset, undef  out  1 each  micro-op controls.
REQ-015 write_reg_sel, read_reg_sel1, read_reg_sel2  out  REG_W each  register selects.
REQ-016 immediate_val, jump_addr, mem_im_addr  out  DATA_W each  operand values.

Function
REQ-017 Decode: instr[27:26]=00 ALU, 01 single memory, 10 with instr[25]=1 branch, 10 with instr[25]=0 block transfer, 11 undefined.
REQ-018 ALU: alu_op=instr[24:21], read1=instr[19:16], write=instr[15:12], we=1; instr[25]=0 gives read2=instr[3:0]; instr[25]=1 gives immediate=1 and immediate_val=zero-extended instr[7:0].
REQ-019 Memory: read1=instr[19:16]; instr[20]=1 gives load (mem_load=1, we=1, write=instr[15:12]); instr[20]=0 gives store (mem_store=1, read2=instr[15:12]); instr[25]=0 gives mem_base_offset=1 and mem_im_addr=zero-extended instr[11:0], meaning address = R[read1]+mem_im_addr; instr[25]=1 gives address = R[read1].
REQ-020 Branch: jump_en=1, jump_addr = sign-extended instr[23:0] shifted left by BR_SHIFT, truncated to DATA_W.
REQ-021 Undefined: emits a NOP with undef=1 for exactly one valid output cycle.
REQ-022 NOP definition: out_valid=1 and all 1-bit controls 0, except undef where REQ-021 applies; select and value fields are don't-care.
REQ-023 Condition instr[31:28] uses ARM semantics EQ..AL (0000-1110); 1111 never passes; a failing condition emits one NOP for any instruction class.
REQ-024 Block transfer (passing condition): list=instr[15:0], base=instr[19:16], L=instr[20], W=instr[21]; emits one micro-op per set list bit in ascending register order; the k-th micro-op (k from 0) is a load or store of register r with read1=base, mem_base_offset=1, mem_im_addr=4*k.
REQ-025 If W=1, a final micro-op ADD is appended: alu_op=0100, read1=write=base, immediate=1, immediate_val=4*popcount(list).
REQ-026 An empty list with W=0 emits one NOP; an empty list with W=1 emits only the ADD with immediate_val=0.
REQ-027 FSM states: IDLE, SEQ. IDLE accepts instructions. Accepting a block transfer that emits 2 or more micro-ops moves IDLE to SEQ. SEQ returns to IDLE after the cycle that emits the last micro-op.
REQ-028 instr_ready = (state==IDLE) && !stall && !rst.
REQ-029 Latency: the micro-op for an accepted instruction, or its first micro-op, appears on the outputs the cycle after acceptance; successive sequence micro-ops follow on consecutive unstalled cycles.
REQ-030 If stall=1, all outputs, the state and the sequence pointer hold.
REQ-031 If flush=1: next-cycle out_valid=0, state becomes IDLE, the pending sequence is dropped, and no instruction is accepted that cycle; flush overrides stall.
REQ-032 If there is no accept and no pending micro-op in an unstalled cycle, out_valid goes to 0 on the next cycle.

Reset
REQ-033 Reset causes out_valid=0, state IDLE, all 1-bit controls 0, and sequence pointer cleared; rst overrides flush, stall and any accept, including mid-sequence.

Verification
REQ-034 ALU immediate: instr=E2812005 (ADD R2,R1,#5, AL) -> next cycle out_valid=1, alu_op=0100, read1=1, write=2, immediate=1, immediate_val=5.
REQ-035 Condition fail: instr=0A000010 (BEQ) with flags=0000 -> one NOP, jump_en=0; the same instruction with flags=0100 -> jump_en=1, jump_addr=00000010 (BR_SHIFT=0).
REQ-036 Block transfer: instr=E8B0000A (LDM R0!,{R1,R3}) -> 3 consecutive micro-ops: load R1 at offset 0, load R3 at offset 4, ADD R0,R0,#8; instr_ready=0 for 2 cycles.
REQ-037 Stall and flush mid-sequence: stall asserted during the 2nd micro-op -> outputs hold; then flush -> out_valid=0, state IDLE, instr_ready=1 the following cycle.
REQ-038 Reset mid-sequence and undefined: rst during SEQ -> all outputs 0 next cycle; instr=EC000000 -> one NOP with undef=1.

Source files
------------

// File: rtl/decode_sequencer.sv
// Instruction decoder that turns one 32-bit instruction word into registered
// micro-ops. Block transfers are expanded into one micro-op per listed
// register, plus an optional base write-back ADD.
//
// state | meaning
// IDLE  | ready for a new instruction; output register holds the last micro-op or a bubble
// SEQ   | expanding a block transfer; more micro-ops are still to be emitted
module decode_sequencer #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 4,
  parameter int BR_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic [3:0]        flags,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [3:0]        alu_op,
  output logic              reg_write_enable,
  output logic              immediate,
  output logic              jump_en,
  output logic              mem_load,
  output logic              mem_store,
  output logic              mem_base_offset,
  output logic              undef,
  output logic [REG_W-1:0]  write_reg_sel,
  output logic [REG_W-1:0]  read_reg_sel1,
  output logic [REG_W-1:0]  read_reg_sel2,
  output logic [DATA_W-1:0] immediate_val,
  output logic [DATA_W-1:0] jump_addr,
  output logic [DATA_W-1:0] mem_im_addr
);

  localparam int EXT_W = DATA_W + 24;

  typedef enum logic {IDLE, SEQ} state_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_op;
    logic              we;
    logic              imm;
    logic              jmp;
    logic              ld;
    logic              st;
    logic              mbo;
    logic              undef;
    logic [REG_W-1:0]  wsel;
    logic [REG_W-1:0]  r1;
    logic [REG_W-1:0]  r2;
    logic [DATA_W-1:0] imm_val;
    logic [DATA_W-1:0] jaddr;
    logic [DATA_W-1:0] maddr;
  } uop_t;

  state_t           state_q, state_d;
  uop_t             uop_q, uop_d;
  logic [15:0]      list_q, list_d;
  logic [REG_W-1:0] base_q, base_d;
  logic             load_q, load_d;
  logic             wb_q, wb_d;
  logic [4:0]       k_q, k_d;

  logic             accept;
  logic             run_seq;
  logic             more;
  logic [15:0]      cur_list;
  logic [REG_W-1:0] cur_base;
  logic             cur_load;
  logic             cur_wb;
  logic [4:0]       cur_k;
  logic [3:0]       low;
  logic [EXT_W-1:0] br_sext;

  // ARM condition codes; flags are {N,Z,C,V}, and 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ok;
    {n, z, cf, v} = f;
    ok = 1'b0;
    case (c)
      4'h0: ok = z;
      4'h1: ok = !z;
      4'h2: ok = cf;
      4'h3: ok = !cf;
      4'h4: ok = n;
      4'h5: ok = !n;
      4'h6: ok = v;
      4'h7: ok = !v;
      4'h8: ok = cf && !z;
      4'h9: ok = !cf || z;
      4'hA: ok = (n == v);
      4'hB: ok = (n != v);
      4'hC: ok = !z && (n == v);
      4'hD: ok = z || (n != v);
      4'hE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] low_bit(input logic [15:0] l);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (l[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // k-th transfer of a block: base plus 4*k, register r loaded or stored.
  function automatic uop_t blk_uop(input logic [3:0] r, input logic [REG_W-1:0] base,
                                   input logic ld, input logic [4:0] k);
    uop_t u;
    u       = '0;
    u.valid = 1'b1;
    u.r1    = base;
    u.mbo   = 1'b1;
    u.maddr = DATA_W'({k, 2'b00});
    if (ld) begin
      u.ld   = 1'b1;
      u.we   = 1'b1;
      u.wsel = REG_W'(r);
    end else begin
      u.st   = 1'b1;
      u.r2   = REG_W'(r);
    end
    return u;
  endfunction

  // Base write-back: base = base + 4*count.
  function automatic uop_t wb_uop(input logic [REG_W-1:0] base, input logic [4:0] k);
    uop_t u;
    u         = '0;
    u.valid   = 1'b1;
    u.alu_op  = 4'b0100;
    u.we      = 1'b1;
    u.imm     = 1'b1;
    u.r1      = base;
    u.wsel    = base;
    u.imm_val = DATA_W'({k, 2'b00});
    return u;
  endfunction

  assign instr_ready = (state_q == IDLE) && !stall && !rst;
  // Flush blocks acceptance even though instr_ready ignores it.
  assign accept      = instr_valid && instr_ready && !flush;
  assign br_sext     = {{DATA_W{instr[23]}}, instr[23:0]};

  // Next micro-op, sequence bookkeeping and next state.
  always_comb begin
    state_d  = state_q;
    uop_d    = uop_q;
    list_d   = list_q;
    base_d   = base_q;
    load_d   = load_q;
    wb_d     = wb_q;
    k_d      = k_q;
    run_seq  = 1'b0;
    more     = 1'b0;
    low      = 4'd0;
    cur_list = list_q;
    cur_base = base_q;
    cur_load = load_q;
    cur_wb   = wb_q;
    cur_k    = k_q;
    if (flush) begin
      uop_d   = '0;
      state_d = IDLE;
      list_d  = '0;
      k_d     = '0;
    end else if (!stall) begin
      if (state_q == SEQ) begin
        run_seq = 1'b1;
      end else if (accept) begin
        uop_d       = '0;
        uop_d.valid = 1'b1;
        if (cond_pass(instr[31:28], flags)) begin
          case (instr[27:26])
            2'b00: begin
              uop_d.alu_op = instr[24:21];
              uop_d.r1     = REG_W'(instr[19:16]);
              uop_d.wsel   = REG_W'(instr[15:12]);
              uop_d.we     = 1'b1;
              if (instr[25]) begin
                uop_d.imm     = 1'b1;
                uop_d.imm_val = DATA_W'(instr[7:0]);
              end else begin
                uop_d.r2 = REG_W'(instr[3:0]);
              end
            end
            2'b01: begin
              uop_d.r1 = REG_W'(instr[19:16]);
              if (instr[20]) begin
                uop_d.ld   = 1'b1;
                uop_d.we   = 1'b1;
                uop_d.wsel = REG_W'(instr[15:12]);
              end else begin
                uop_d.st = 1'b1;
                uop_d.r2 = REG_W'(instr[15:12]);
              end
              if (!instr[25]) begin
                uop_d.mbo   = 1'b1;
                uop_d.maddr = DATA_W'(instr[11:0]);
              end
            end
            2'b10: begin
              if (instr[25]) begin
                uop_d.jmp   = 1'b1;
                uop_d.jaddr = DATA_W'(br_sext << BR_SHIFT);
              end else begin
                run_seq  = 1'b1;
                cur_list = instr[15:0];
                cur_base = REG_W'(instr[19:16]);
                cur_load = instr[20];
                cur_wb   = instr[21];
                cur_k    = 5'd0;
              end
            end
            default: uop_d.undef = 1'b1;
          endcase
        end
      end else begin
        uop_d = '0;
      end
    end

    // One step of a block transfer, shared by the accept cycle and SEQ.
    if (run_seq) begin
      base_d = cur_base;
      load_d = cur_load;
      wb_d   = cur_wb;
      if (cur_list != '0) begin
        low    = low_bit(cur_list);
        uop_d  = blk_uop(low, cur_base, cur_load, cur_k);
        list_d = cur_list & ~(16'd1 << low);
        k_d    = cur_k + 5'd1;
        more   = (list_d != '0) || cur_wb;
      end else if (cur_wb) begin
        uop_d = wb_uop(cur_base, cur_k);
      end else begin
        uop_d       = '0;
        uop_d.valid = 1'b1;
      end
      if (!more) begin
        list_d = '0;
        k_d    = '0;
      end
      state_d = more ? SEQ : IDLE;
    end
  end

  // State, output register and sequence pointer; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      uop_q   <= '0;
      list_q  <= '0;
      base_q  <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      list_q  <= list_d;
      base_q  <= base_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      k_q     <= k_d;
    end
  end

  assign out_valid        = uop_q.valid;
  assign alu_op           = uop_q.alu_op;
  assign reg_write_enable = uop_q.we;
  assign immediate        = uop_q.imm;
  assign jump_en          = uop_q.jmp;
  assign mem_load         = uop_q.ld;
  assign mem_store        = uop_q.st;
  assign mem_base_offset  = uop_q.mbo;
  assign undef            = uop_q.undef;
  assign write_reg_sel    = uop_q.wsel;
  assign read_reg_sel1    = uop_q.r1;
  assign read_reg_sel2    = uop_q.r2;
  assign immediate_val    = uop_q.imm_val;
  assign jump_addr        = uop_q.jaddr;
  assign mem_im_addr      = uop_q.maddr;

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: a queue-based reference model predicts each
// cycle's micro-op; directed cases pin known encodings, then random traffic.
module tb_decode_sequencer;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 4;
  localparam int BR_SHIFT = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic [31:0]       instr = '0;
  logic              instr_ready;
  logic [3:0]        flags = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [3:0]        alu_op;
  logic              reg_write_enable, immediate, jump_en, mem_load, mem_store;
  logic              mem_base_offset, undef;
  logic [REG_W-1:0]  write_reg_sel, read_reg_sel1, read_reg_sel2;
  logic [DATA_W-1:0] immediate_val, jump_addr, mem_im_addr;

  decode_sequencer #(.DATA_W(DATA_W), .REG_W(REG_W), .BR_SHIFT(BR_SHIFT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .flags(flags), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_op(alu_op), .reg_write_enable(reg_write_enable),
    .immediate(immediate), .jump_en(jump_en), .mem_load(mem_load),
    .mem_store(mem_store), .mem_base_offset(mem_base_offset), .undef(undef),
    .write_reg_sel(write_reg_sel), .read_reg_sel1(read_reg_sel1),
    .read_reg_sel2(read_reg_sel2), .immediate_val(immediate_val),
    .jump_addr(jump_addr), .mem_im_addr(mem_im_addr)
  );

  always #5 clk = ~clk;

  // Expected micro-op; c_* mark which value fields matter, z means controls must be 0.
  typedef struct {
    bit v, z;
    bit [3:0] alu, wsel, r1, r2;
    bit we, imm, jmp, ld, st, mbo, und;
    bit [31:0] ival, jaddr, maddr;
    bit c_alu, c_w, c_r1, c_r2, c_iv, c_ja, c_ma;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   known = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, vv;
    {n, z, cc, vv} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return vv;
      4'h7: return !vv;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == vv;
      4'hB: return n != vv;
      4'hC: return !z && (n == vv);
      4'hD: return z || (n != vv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expand an accepted instruction into the full list of micro-ops it must produce.
  function automatic void build(input logic [31:0] i, input logic [3:0] f);
    exp_t e;
    int n;
    e = blank();
    e.v = 1;
    if (!cond_ok(i[31:28], f)) begin
      q.push_back(e);
      return;
    end
    case (i[27:26])
      2'b00: begin
        e.alu = i[24:21]; e.c_alu = 1; e.r1 = i[19:16]; e.c_r1 = 1;
        e.wsel = i[15:12]; e.c_w = 1; e.we = 1;
        if (i[25]) begin e.imm = 1; e.ival = 32'(i[7:0]); e.c_iv = 1; end
        else begin e.r2 = i[3:0]; e.c_r2 = 1; end
        q.push_back(e);
      end
      2'b01: begin
        e.r1 = i[19:16]; e.c_r1 = 1;
        if (i[20]) begin e.ld = 1; e.we = 1; e.wsel = i[15:12]; e.c_w = 1; end
        else begin e.st = 1; e.r2 = i[15:12]; e.c_r2 = 1; end
        if (!i[25]) begin e.mbo = 1; e.maddr = 32'(i[11:0]); e.c_ma = 1; end
        q.push_back(e);
      end
      2'b10: begin
        if (i[25]) begin
          e.jmp = 1; e.jaddr = {{8{i[23]}}, i[23:0]} << BR_SHIFT; e.c_ja = 1;
          q.push_back(e);
        end else begin
          n = 0;
          for (int r = 0; r < 16; r++) begin
            if (i[r]) begin
              e = blank(); e.v = 1; e.r1 = i[19:16]; e.c_r1 = 1; e.mbo = 1;
              e.maddr = 32'(4 * n); e.c_ma = 1;
              if (i[20]) begin e.ld = 1; e.we = 1; e.wsel = 4'(r); e.c_w = 1; end
              else begin e.st = 1; e.r2 = 4'(r); e.c_r2 = 1; end
              q.push_back(e);
              n++;
            end
          end
          if (i[21]) begin
            e = blank(); e.v = 1; e.alu = 4'b0100; e.c_alu = 1; e.r1 = i[19:16]; e.c_r1 = 1;
            e.wsel = i[19:16]; e.c_w = 1; e.we = 1; e.imm = 1; e.ival = 32'(4 * n); e.c_iv = 1;
            q.push_back(e);
          end
          if (n == 0 && !i[21]) begin
            e = blank(); e.v = 1;
            q.push_back(e);
          end
        end
      end
      default: begin
        e.und = 1;
        q.push_back(e);
      end
    endcase
  endfunction

  function automatic bit m_ready(input bit s, input bit r);
    return (q.size() == 0) && !s && !r;
  endfunction

  task automatic model_step(input bit v, input logic [31:0] i, input logic [3:0] f,
                            input bit s, input bit fl, input bit r);
    bit rdy;
    rdy = m_ready(s, r);
    if (r) begin
      q.delete(); cur = blank(); cur.z = 1; known = 1;
    end else if (fl) begin
      q.delete(); cur = blank();
    end else if (s) begin
      cur = cur;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (v && rdy) begin
      build(i, f); cur = q.pop_front();
    end else begin
      cur = blank();
    end
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, cur.v);
    if (cur.v || cur.z) begin
      check("reg_write_enable", reg_write_enable, cur.we);
      check("immediate", immediate, cur.imm);
      check("jump_en", jump_en, cur.jmp);
      check("mem_load", mem_load, cur.ld);
      check("mem_store", mem_store, cur.st);
      check("mem_base_offset", mem_base_offset, cur.mbo);
      check("undef", undef, cur.und);
    end
    if (cur.v) begin
      if (cur.c_alu) check("alu_op", alu_op, cur.alu);
      if (cur.c_w)   check("write_reg_sel", write_reg_sel, cur.wsel);
      if (cur.c_r1)  check("read_reg_sel1", read_reg_sel1, cur.r1);
      if (cur.c_r2)  check("read_reg_sel2", read_reg_sel2, cur.r2);
      if (cur.c_iv)  check("immediate_val", immediate_val, cur.ival);
      if (cur.c_ja)  check("jump_addr", jump_addr, cur.jaddr);
      if (cur.c_ma)  check("mem_im_addr", mem_im_addr, cur.maddr);
    end
  endtask

  // One clock: check outputs, drive inputs, check ready, then advance the model.
  task automatic cycle(input bit v, input logic [31:0] i, input logic [3:0] f,
                       input bit s, input bit fl, input bit r);
    @(negedge clk);
    if (known) compare_outputs();
    instr_valid = v; instr = i; flags = f; stall = s; flush = fl; rst = r;
    #1;
    if (known) check("instr_ready", instr_ready, m_ready(s, r));
    @(posedge clk);
    model_step(v, i, f, s, fl, r);
  endtask

  function automatic logic [6:0] ctrls();
    return {reg_write_enable, immediate, jump_en, mem_load, mem_store, mem_base_offset, undef};
  endfunction

  initial begin
    cycle(0, 32'h0, 4'h0, 0, 0, 1);
    cycle(0, 32'h0, 4'h0, 0, 0, 1);
    #1;
    check("lit_reset_valid", out_valid, 0);
    check("lit_reset_ctrls", ctrls(), 0);

    cycle(1, 32'hE2812005, 4'h0, 0, 0, 0);
    #1;
    check("lit_add_valid", out_valid, 1);
    check("lit_add_aluop", alu_op, 4'b0100);
    check("lit_add_read1", read_reg_sel1, 1);
    check("lit_add_write", write_reg_sel, 2);
    check("lit_add_imm", immediate, 1);
    check("lit_add_immval", immediate_val, 5);

    cycle(1, 32'h0A000010, 4'b0000, 0, 0, 0);
    #1;
    check("lit_beq_fail_valid", out_valid, 1);
    check("lit_beq_fail_jump", jump_en, 0);
    cycle(1, 32'h0A000010, 4'b0100, 0, 0, 0);
    #1;
    check("lit_beq_jump", jump_en, 1);
    check("lit_beq_addr", jump_addr, 32'h00000010);

    cycle(1, 32'hE8B0000A, 4'h0, 0, 0, 0);
    #1;
    check("lit_ldm0_load", mem_load, 1);
    check("lit_ldm0_write", write_reg_sel, 1);
    check("lit_ldm0_off", mem_im_addr, 0);
    check("lit_ldm0_ready", instr_ready, 0);
    cycle(1, 32'hE2812005, 4'h0, 0, 0, 0);
    #1;
    check("lit_ldm1_write", write_reg_sel, 3);
    check("lit_ldm1_off", mem_im_addr, 4);
    check("lit_ldm1_ready", instr_ready, 0);
    cycle(0, 32'h0, 4'h0, 0, 0, 0);
    #1;
    check("lit_ldm2_aluop", alu_op, 4'b0100);
    check("lit_ldm2_immval", immediate_val, 8);
    check("lit_ldm2_write", write_reg_sel, 0);
    check("lit_ldm2_ready", instr_ready, 1);

    cycle(1, 32'hE8B0000A, 4'h0, 0, 0, 0);
    cycle(0, 32'h0, 4'h0, 0, 0, 0);
    cycle(0, 32'h0, 4'h0, 1, 0, 0);
    #1;
    check("lit_stall_write", write_reg_sel, 3);
    check("lit_stall_off", mem_im_addr, 4);
    check("lit_stall_valid", out_valid, 1);
    cycle(0, 32'h0, 4'h0, 1, 1, 0);
    #1;
    check("lit_flush_valid", out_valid, 0);
    stall = 0; flush = 0;
    #1;
    check("lit_flush_ready", instr_ready, 1);

    cycle(1, 32'hE8B0000A, 4'h0, 0, 0, 0);
    cycle(1, 32'hE2812005, 4'h0, 1, 1, 1);
    #1;
    check("lit_rst_mid_valid", out_valid, 0);
    check("lit_rst_mid_ctrls", ctrls(), 0);
    cycle(1, 32'hEC000000, 4'h0, 0, 0, 0);
    #1;
    check("lit_undef_valid", out_valid, 1);
    check("lit_undef_flag", undef, 1);
    cycle(0, 32'h0, 4'h0, 0, 0, 0);
    #1;
    check("lit_undef_once", out_valid, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      ri = $urandom;
      if ($urandom_range(0, 3) != 0) ri[31:28] = 4'hE;
      if ($urandom_range(0, 2) == 0) ri[27:25] = 3'b100;
      if (ri[27:25] == 3'b100) begin
        case ($urandom_range(0, 3))
          0: ri[15:0] = 16'h0;
          1: ri[15:0] = ri[15:0] & 16'($urandom) & 16'($urandom);
          default: ri[15:0] = ri[15:0];
        endcase
      end
      cycle($urandom_range(0, 9) < 8, ri, 4'($urandom), $urandom_range(0, 9) < 2,
            $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
